store_buffer: RTL and testbench



---
 rtl/pcpu_pkg.sv | 32 +++
 rtl/sb_fwd_merge.sv | 34 +++
 rtl/store_buffer.sv | 136 +++++++++++++
 tb/tb_store_buffer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcpu_pkg.sv
// Shared pipeline types for the store buffer: entry layout, drain FSM states, default sizing
// and the per-byte-lane merge helper used by both the enqueue path and the forwarding path.
package pcpu_pkg;

  localparam int SB_DEPTH_DEF = 4;
  localparam int SB_AW_DEF    = 32;

  typedef struct packed {
    logic                 valid;
    logic [SB_AW_DEF-3:0] waddr;
    logic [31:0]          data;
    logic [3:0]           wstrb;
  } sb_entry_t;

  typedef enum logic [0:0] {
    SB_IDLE = 1'b0,
    SB_REQ  = 1'b1
  } sb_state_t;

  // Replace the bytes of old_d selected by strb with the matching bytes of new_d.
  function automatic logic [31:0] sb_lane_merge(input logic [31:0] old_d,
                                                input logic [31:0] new_d,
                                                input logic [3:0]  strb);
    logic [31:0] res;
    res = old_d;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = strb[i] ? new_d[8*i +: 8] : old_d[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/sb_fwd_merge.sv
// Store-to-load forwarding merge: walks the buffer oldest to youngest so that, per byte lane,
// the youngest matching entry with its strobe set supplies the byte; also reports coverage.
module sb_fwd_merge
  import pcpu_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH_DEF,
  parameter int PW    = $clog2(DEPTH)
) (
  input  sb_entry_t            i_entries [DEPTH],
  input  logic [PW-1:0]        i_rd_ptr,
  input  logic [SB_AW_DEF-3:0] i_waddr,
  output logic [31:0]          o_data,
  output logic [3:0]           o_cov
);

  logic [PW-1:0] w_idx;
  logic [3:0]    w_strb;

  // Age-ordered merge; later (younger) entries overwrite earlier lanes.
  always_comb begin
    o_data = 32'h0;
    o_cov  = 4'h0;
    w_idx  = i_rd_ptr;
    w_strb = 4'h0;
    for (int age = 0; age < DEPTH; age++) begin
      w_idx  = i_rd_ptr + PW'(age);
      w_strb = (i_entries[w_idx].valid && (i_entries[w_idx].waddr == i_waddr))
               ? i_entries[w_idx].wstrb : 4'h0;
      o_data = sb_lane_merge(o_data, i_entries[w_idx].data, w_strb);
      o_cov  = o_cov | w_strb;
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-store FIFO between MEM and the L1 write port with in-order drain and byte forwarding.
// Optional STORE_COALESCE_EN merges a store into the youngest entry when the word address matches.
module store_buffer
  import pcpu_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH_DEF,
  parameter int AW    = SB_AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          st_valid,
  output logic          st_ready,
  input  logic [AW-1:0] st_addr,
  input  logic [31:0]   st_data,
  input  logic [3:0]    st_wstrb,
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_addr,
  input  logic [3:0]    ld_bmask,
  output logic          ld_hit,
  output logic [31:0]   ld_data,
  output logic          ld_stall,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_wstrb,
  input  logic          mem_ack,
  output logic          sb_empty
);

  localparam int PW = $clog2(DEPTH);

  sb_entry_t     r_entries [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;
  sb_state_t     r_state;

  logic          w_full;
  logic          w_ack;
  logic          w_push;
  logic [AW-3:0] w_st_waddr;
  logic [AW-3:0] w_ld_waddr;
  logic [31:0]   w_fwd_data;
  logic [3:0]    w_cov;
  logic [3:0]    w_need;
  logic          w_unused;

  assign w_st_waddr = st_addr[AW-1:2];
  assign w_ld_waddr = ld_addr[AW-1:2];
  assign w_unused   = ^{st_addr[1:0], ld_addr[1:0]};
  assign w_full     = (r_count == (PW+1)'(DEPTH));
  assign w_ack      = (r_state == SB_REQ) && mem_ack;

`ifdef STORE_COALESCE_EN
  logic [PW-1:0] w_tail;
  logic          w_coal_hit;
  logic          w_merge;

  // The youngest entry may absorb the store unless it is the head being offered to L1.
  assign w_tail     = r_wr_ptr - PW'(1);
  assign w_coal_hit = r_entries[w_tail].valid
                      && (r_entries[w_tail].waddr == w_st_waddr)
                      && !((r_state == SB_REQ) && (w_tail == r_rd_ptr));
  assign st_ready   = !w_full || w_coal_hit;
  assign w_merge    = st_valid && w_coal_hit;
  assign w_push     = st_valid && st_ready && !w_coal_hit;
`else
  assign st_ready   = !w_full;
  assign w_push     = st_valid && st_ready;
`endif

  // Entry storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_entries[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_ack) begin
        r_entries[r_rd_ptr].valid <= 1'b0;
        r_rd_ptr                  <= r_rd_ptr + PW'(1);
      end
      if (w_push) begin
        r_entries[r_wr_ptr] <= '{valid: 1'b1, waddr: w_st_waddr, data: st_data, wstrb: st_wstrb};
        r_wr_ptr            <= r_wr_ptr + PW'(1);
      end
`ifdef STORE_COALESCE_EN
      if (w_merge) begin
        r_entries[w_tail].data  <= sb_lane_merge(r_entries[w_tail].data, st_data, st_wstrb);
        r_entries[w_tail].wstrb <= r_entries[w_tail].wstrb | st_wstrb;
      end
`endif
      case ({w_push, w_ack})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Drain FSM: one request per entry, always passing through idle between drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= SB_IDLE;
    end else begin
      case (r_state)
        SB_IDLE: r_state <= (r_count != (PW+1)'(0)) ? SB_REQ : SB_IDLE;
        SB_REQ:  r_state <= w_ack ? SB_IDLE : SB_REQ;
        default: r_state <= SB_IDLE;
      endcase
    end
  end

  assign mem_req   = (r_state == SB_REQ);
  assign mem_addr  = {r_entries[r_rd_ptr].waddr, 2'b00};
  assign mem_wdata = r_entries[r_rd_ptr].data;
  assign mem_wstrb = r_entries[r_rd_ptr].wstrb;
  assign sb_empty  = (r_count == (PW+1)'(0)) && (r_state == SB_IDLE);

  sb_fwd_merge #(.DEPTH(DEPTH), .PW(PW)) u_fwd (
    .i_entries (r_entries),
    .i_rd_ptr  (r_rd_ptr),
    .i_waddr   (w_ld_waddr),
    .o_data    (w_fwd_data),
    .o_cov     (w_cov)
  );

  assign w_need   = w_cov & ld_bmask;
  assign ld_hit   = ld_valid && (w_need == ld_bmask);
  assign ld_stall = ld_valid && (w_need != 4'h0) && (w_need != ld_bmask);
  assign ld_data  = ld_valid ? w_fwd_data : 32'h0;

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: a queue-based reference model predicts each cycle's outputs,
// loads and drained writes; a negedge monitor pops the expectations and compares.
`timescale 1ns/1ps
module tb_store_buffer;
  import pcpu_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          st_valid = 1'b0;
  logic          st_ready;
  logic [AW-1:0] st_addr = '0;
  logic [31:0]   st_data = '0;
  logic [3:0]    st_wstrb = 4'h0;
  logic          ld_valid = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [3:0]    ld_bmask = 4'h0;
  logic          ld_hit;
  logic [31:0]   ld_data;
  logic          ld_stall;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_wstrb;
  logic          mem_ack = 1'b0;
  logic          sb_empty;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data), .st_wstrb(st_wstrb),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_bmask(ld_bmask),
    .ld_hit(ld_hit), .ld_data(ld_data), .ld_stall(ld_stall),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ack(mem_ack), .sb_empty(sb_empty)
  );

  typedef struct { logic [29:0] waddr; logic [31:0] data; logic [3:0] wstrb; } m_ent_t;
  typedef struct { bit chk; logic st_ready; logic mem_req; logic sb_empty;
                   logic [31:0] maddr; logic [31:0] mdata; logic [3:0] mstrb; } stat_t;
  typedef struct { logic hit; logic stall; logic [31:0] data; } ld_t;

  m_ent_t mq[$];        // model contents, oldest first
  logic   m_req = 1'b0; // model: a drain request is outstanding this cycle
  stat_t  stat_q[$];
  ld_t    ld_q[$];
  m_ent_t drain_q[$];

  int n_checks = 0;
  int n_errors = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] put_bytes(input logic [31:0] base, input logic [31:0] nd,
                                            input logic [3:0] en);
    logic [31:0] r;
    r = base;
    for (int b = 0; b < 4; b++) if (en[b]) r[8*b +: 8] = nd[8*b +: 8];
    return r;
  endfunction

  task automatic step(input logic sv, input logic [31:0] sa, input logic [31:0] sd, input logic [3:0] ss,
                      input logic lv, input logic [31:0] la, input logic [3:0] lb,
                      input logic ak, input logic rs);
    stat_t s;
    ld_t   l;
    logic  full, coal, acc, ackd;
    logic [3:0]  cov;
    logic [31:0] fd;
    int sz;
    rst = rs; st_valid = sv; st_addr = sa; st_data = sd; st_wstrb = ss;
    ld_valid = lv && !rs; ld_addr = la; ld_bmask = lb; mem_ack = ak;
    sz = mq.size();
    s = '{chk: 1'b0, st_ready: 1'b0, mem_req: 1'b0, sb_empty: 1'b0, maddr: 32'h0, mdata: 32'h0, mstrb: 4'h0};
    if (rs) begin
      stat_q.push_back(s);
      mq.delete();
      m_req = 1'b0;
    end else begin
      full = (sz == DEPTH);
      coal = 1'b0;
`ifdef STORE_COALESCE_EN
      if (sz > 0) coal = (mq[sz-1].waddr == sa[31:2]) && !(m_req && sz == 1);
`endif
      s.chk = 1'b1;
      s.st_ready = !full || coal;
      s.mem_req  = m_req;
      s.sb_empty = (sz == 0) && !m_req;
      if (m_req) begin
        s.maddr = {mq[0].waddr, 2'b00}; s.mdata = mq[0].data; s.mstrb = mq[0].wstrb;
      end
      stat_q.push_back(s);
      if (lv) begin
        cov = 4'h0; fd = 32'h0;
        foreach (mq[i]) if (mq[i].waddr == la[31:2]) begin
          fd  = put_bytes(fd, mq[i].data, mq[i].wstrb);
          cov = cov | mq[i].wstrb;
        end
        l.hit   = ((cov & lb) == lb);
        l.stall = ((cov & lb) != 4'h0) && !l.hit;
        l.data  = fd;
        ld_q.push_back(l);
      end
      acc  = sv && s.st_ready;
      ackd = m_req && ak;
      m_req = m_req ? !ackd : (sz != 0);
      if (ackd) begin
        drain_q.push_back(mq[0]);
        void'(mq.pop_front());
      end
      if (acc) begin
        if (coal) begin
          mq[mq.size()-1].data  = put_bytes(mq[mq.size()-1].data, sd, ss);
          mq[mq.size()-1].wstrb = mq[mq.size()-1].wstrb | ss;
        end else begin
          mq.push_back('{waddr: sa[31:2], data: sd, wstrb: ss});
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ak);
    step(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 4'h0, ak, 1'b0);
  endtask
  task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic ak);
    step(1'b1, a, d, s, 1'b0, 32'h0, 4'h0, ak, 1'b0);
  endtask
  task automatic ld(input logic [31:0] a, input logic [3:0] b);
    step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, a, b, 1'b0, 1'b0);
  endtask
  task automatic drain_all();
    for (int k = 0; k < 40 && (mq.size() != 0 || m_req); k++) idle(1'b1);
  endtask
  task automatic wait_req();
    for (int k = 0; k < 5 && !m_req; k++) idle(1'b0);
  endtask

  stat_t  mon_s;
  ld_t    mon_l;
  m_ent_t mon_d;

  // Monitor: one status record per cycle, plus load and drain records when the DUT presents them.
  always @(negedge clk) begin
    if (stat_q.size() != 0) begin
      mon_s = stat_q.pop_front();
      if (mon_s.chk) begin
        chk("st_ready", {31'h0, st_ready}, {31'h0, mon_s.st_ready});
        chk("mem_req",  {31'h0, mem_req},  {31'h0, mon_s.mem_req});
        chk("sb_empty", {31'h0, sb_empty}, {31'h0, mon_s.sb_empty});
        if (mon_s.mem_req) begin
          chk("mem_addr",  mem_addr,  mon_s.maddr);
          chk("mem_wdata", mem_wdata, mon_s.mdata);
          chk("mem_wstrb", {28'h0, mem_wstrb}, {28'h0, mon_s.mstrb});
        end
        if (ld_valid) begin
          if (ld_q.size() == 0) begin
            chk("ld_unexpected", 32'h1, 32'h0);
          end else begin
            mon_l = ld_q.pop_front();
            chk("ld_hit",   {31'h0, ld_hit},   {31'h0, mon_l.hit});
            chk("ld_stall", {31'h0, ld_stall}, {31'h0, mon_l.stall});
            chk("ld_data",  ld_data, mon_l.data);
          end
        end
        if (mem_req && mem_ack) begin
          if (drain_q.size() == 0) begin
            chk("drain_unexpected", 32'h1, 32'h0);
          end else begin
            mon_d = drain_q.pop_front();
            chk("drain_addr", mem_addr, {mon_d.waddr, 2'b00});
            chk("drain_data", mem_wdata, mon_d.data);
          end
        end
      end
    end
  end

  logic [31:0] pool [4];

  initial begin
    pool[0] = 32'h1000; pool[1] = 32'h1004; pool[2] = 32'h2000; pool[3] = 32'h3000;
    @(posedge clk);
    #1;
    step(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1);
    idle(1'b0);
    ld(32'h1000, 4'hF);
    // full-word forward
    st(32'h1000, 32'hDEADBEEF, 4'hF, 1'b0);
    ld(32'h1000, 4'hF);
    drain_all();
    // partial coverage stalls, then misses after drain
    st(32'h2000, 32'h000000AA, 4'h1, 1'b0);
    ld(32'h2000, 4'hF);
    drain_all();
    ld(32'h2000, 4'hF);
    // fill, reject fifth, ack frees a slot next cycle, in-order drain
    st(32'h0100, 32'hA0A0A0A0, 4'hF, 1'b0);
    st(32'h0104, 32'hA1A1A1A1, 4'hF, 1'b0);
    st(32'h0108, 32'hA2A2A2A2, 4'hF, 1'b0);
    st(32'h010C, 32'hA3A3A3A3, 4'hF, 1'b0);
    st(32'h0110, 32'hA4A4A4A4, 4'hF, 1'b0);
    idle(1'b1);
    idle(1'b0);
    drain_all();
    // full with ack in the store cycle
    st(32'h0200, 32'h1, 4'hF, 1'b0);
    st(32'h0204, 32'h2, 4'hF, 1'b0);
    st(32'h0208, 32'h3, 4'hF, 1'b0);
    st(32'h020C, 32'h4, 4'hF, 1'b0);
    wait_req();
    st(32'h0210, 32'h5, 4'hF, 1'b1);
    st(32'h0214, 32'h6, 4'hF, 1'b0);
    drain_all();
    // youngest wins
    st(32'h3000, 32'h11111111, 4'hF, 1'b0);
    st(32'h3000, 32'h22222222, 4'hF, 1'b0);
    ld(32'h3000, 4'hF);
    drain_all();
    // reset mid-drain
    st(32'h5000, 32'h55, 4'hF, 1'b0);
    st(32'h5004, 32'h66, 4'hF, 1'b0);
    st(32'h5008, 32'h77, 4'hF, 1'b0);
    wait_req();
    step(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1);
    idle(1'b0);
    ld(32'h5000, 4'hF);
    // repeated word address without ack
    st(32'h4000, 32'hCAFE0000, 4'hF, 1'b0);
    st(32'h4000, 32'h0000BABE, 4'hF, 1'b0);
    idle(1'b0);
    ld(32'h4000, 4'hF);
    drain_all();
    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0,
           pool[$urandom_range(0, 3)] | 32'($urandom_range(0, 3)), $urandom, 4'($urandom_range(1, 15)),
           $urandom_range(0, 1) == 1, pool[$urandom_range(0, 3)] | 32'($urandom_range(0, 3)),
           4'($urandom_range(1, 15)),
           ($urandom_range(0, 9) < 4) ? 1'b1 : 1'b0,
           ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
    end
    drain_all();
    @(negedge clk);
    #1;
    chk("stat_q_left",  32'(stat_q.size()),  32'h0);
    chk("ld_q_left",    32'(ld_q.size()),    32'h0);
    chk("drain_q_left", 32'(drain_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
